// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master
//  Function : Single-outstanding APB master. It turns a valid/ready command
//             into an APB SETUP/ACCESS transfer and returns a one-cycle
//             response pulse. A bounded ACCESS wait aborts with an error.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master #(
  parameter int TIMEOUT_CYCLES = 16   // ACCESS cycles allowed before abort, 2..255
) (
  input  logic        pclk,
  input  logic        presetn,
  // local command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  // local response side
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // APB bus side
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [31:0] prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter value at which one more not-ready ACCESS edge means timeout.
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [7:0]  wait_cnt_q;

  // Ready is a decode of the state register; it is high in the completion
  // cycle too, which is what lets transfers run back to back.
  assign cmd_ready = (state_q == IDLE);

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Transfer sequencer: state, APB outputs, response and wait counter.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'd0;
      pwdata_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= 8'd0;
    end else begin
      // Response is a single-cycle pulse; data/err hold until overwritten.
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q    <= SETUP;
            psel_q     <= 1'b1;
            penable_q  <= 1'b0;
            pwrite_q   <= cmd_write;
            paddr_q    <= cmd_addr;
            // Reads drive zero so stale write data never appears on the bus.
            pwdata_q   <= cmd_write ? cmd_wdata : 32'd0;
            wait_cnt_q <= 8'd0;
          end
        end

        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end

        ACCESS: begin
          if (pready) begin
            // Completion wins even on the edge that would otherwise time out.
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= pslverr;
            rsp_rdata_q <= pwrite_q ? 32'd0 : prdata;
          end else if (wait_cnt_q == c_wait_last) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master
//  Function : Self-checking bench for apb_master. Directed and random
//             transfers against a scripted APB slave, scoreboarded responses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_master;

  localparam int T = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = 32'd0;

  apb_master #(.TIMEOUT_CYCLES(T)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          acc;   // edge that enters SETUP
    int          done;  // edge that completes the transfer
  } exp_t;

  typedef struct {
    int          wt;
    logic        er;
    logic [31:0] rd;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  int checks = 0;
  int failures = 0;

  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  logic [31:0] last_addr = 32'd0;
  logic        last_w = 1'b0;
  logic [31:0] last_wdata = 32'd0;
  logic        mon_en = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Scripted slave: pready rises on the ACCESS cycle selected by the plan;
  // before that, pslverr/prdata carry noise that the master must ignore.
  initial begin : slave
    plan_t cur;
    int    acc_cnt;
    cur = '{wt: 0, er: 1'b0, rd: 32'd0};
    acc_cnt = 0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        acc_cnt = 0;
      end else if (psel && !penable) begin
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        acc_cnt = 0;
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end else if (psel && penable) begin
        if (acc_cnt == cur.wt) begin
          pready  = 1'b1;
          pslverr = cur.er;
          prdata  = cur.rd;
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom);
          prdata  = $urandom;
        end
        acc_cnt++;
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on each response and checks bus behaviour
  // against the transfer the model says is in flight.
  initial begin : monitor
    exp_t e;
    logic busy;
    forever begin
      @(negedge pclk);
      if (presetn && mon_en) begin
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("rsp_valid_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_cycle", 32'(cyc), 32'(e.done));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_rdata", rsp_rdata, e.rdata);
            last_rdata = e.rdata; last_err = e.err;
            last_addr = e.addr; last_w = e.w; last_wdata = e.wdata;
          end
        end else begin
          if (exp_q.size() > 0 && cyc > exp_q[0].done) begin
            chk("rsp_valid_missing", 32'(rsp_valid), 32'd1);
            e = exp_q.pop_front();
            last_rdata = e.rdata; last_err = e.err;
            last_addr = e.addr; last_w = e.w; last_wdata = e.wdata;
          end
          chk("rsp_rdata_hold", rsp_rdata, last_rdata);
          chk("rsp_err_hold", 32'(rsp_err), 32'(last_err));
        end
        busy = (exp_q.size() != 0);
        chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
        chk("psel", 32'(psel), 32'(busy));
        if (busy) begin
          chk("penable", 32'(penable), 32'(cyc != exp_q[0].acc));
          chk("paddr", paddr, exp_q[0].addr);
          chk("pwrite", 32'(pwrite), 32'(exp_q[0].w));
          chk("pwdata", pwdata, exp_q[0].wdata);
        end else begin
          chk("penable_idle", 32'(penable), 32'd0);
          chk("paddr_idle_hold", paddr, last_addr);
          chk("pwrite_idle_hold", 32'(pwrite), 32'(last_w));
          chk("pwdata_idle_hold", pwdata, last_wdata);
        end
      end
    end
  end

  // Present a command, wait for the master to take it, and record both the
  // slave behaviour and the response the rules predict for it.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int wt, input logic er, input logic [31:0] rd);
    int   n;
    exp_t e;
    logic tmo;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready) begin
      @(negedge pclk); #1;
      n++;
      if (n > 200) begin
        failures++;
        $display("FAIL cmd_ready_wait actual=0 required=1 after %0d cycles", n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "cmd_ready never returned");
      end
    end
    tmo     = (wt >= T);
    e.w     = w;
    e.addr  = a;
    e.wdata = w ? d : 32'd0;
    e.err   = tmo ? 1'b1 : er;
    e.rdata = (tmo || w) ? 32'd0 : rd;
    e.acc   = cyc + 1;
    e.done  = e.acc + 2 + ((wt < T - 1) ? wt : T - 1);
    exp_q.push_back(e);
    plan_q.push_back('{wt: wt, er: er, rd: rd});
    @(negedge pclk); #1;
  endtask

  task automatic idle_gap(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin @(negedge pclk); #1; end
  endtask

  initial begin : driver
    int n;
    // reset state
    repeat (3) @(negedge pclk);
    #1;
    chk("reset_psel", 32'(psel), 32'd0);
    chk("reset_penable", 32'(penable), 32'd0);
    chk("reset_pwrite", 32'(pwrite), 32'd0);
    chk("reset_paddr", paddr, 32'd0);
    chk("reset_pwdata", pwdata, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    #1 presetn = 1'b1;
    @(negedge pclk); #1;
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    mon_en = 1'b1;

    // directed cases
    issue(1'b1, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'h0);        idle_gap(2);
    issue(1'b0, 32'h0, 32'h0, 1, 1'b0, 32'hDEADBEEF);        idle_gap(2);
    issue(1'b1, 32'h4, 32'h12345678, 0, 1'b1, 32'h0);        idle_gap(2);
    issue(1'b0, 32'h8, 32'h0, 50, 1'b0, 32'hCAFEF00D);       idle_gap(2);
    issue(1'b0, 32'hC, 32'h0, T - 1, 1'b0, 32'hA5A5A5A5);    idle_gap(2);
    issue(1'b0, 32'h10, 32'h0, T, 1'b0, 32'h5A5A5A5A);       idle_gap(2);
    // back to back with cmd_valid held
    issue(1'b1, 32'h100, 32'h11111111, 1, 1'b0, 32'h0);
    issue(1'b0, 32'h104, 32'h0, 0, 1'b0, 32'h22222222);
    idle_gap(3);

    // reset in the middle of ACCESS, then a normal transfer
    issue(1'b0, 32'h200, 32'h0, 100, 1'b0, 32'h0);
    cmd_valid = 1'b0;
    @(negedge pclk); #1;
    presetn = 1'b0;
    #1;
    chk("async_rst_psel", 32'(psel), 32'd0);
    chk("async_rst_penable", 32'(penable), 32'd0);
    chk("async_rst_paddr", paddr, 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_q.delete();
    plan_q.delete();
    last_rdata = 32'd0; last_err = 1'b0;
    last_addr = 32'd0; last_w = 1'b0; last_wdata = 32'd0;
    @(negedge pclk); #2;
    presetn = 1'b1;
    @(negedge pclk); #1;
    issue(1'b0, 32'h300, 32'h0, 2, 1'b0, 32'h0BADCAFE);
    idle_gap(1);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)),
            1'(($urandom % 4) == 0), $urandom);
      n = int'($urandom_range(0, 2));
      if (n > 0) idle_gap(n);
    end

    cmd_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge pclk); #1;
      n++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
